wb_port_arb: RTL and testbench
==============================

WB_PORT_ARB -- requirements
Module: wb_port_arb

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter STARVE_LIMIT SHALL default to 4 and sets the starvation threshold in cycles (range 1..15).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 wb_we  input  1  pipeline writeback request from MEM/WB.
REQ-006 wb_w_reg_addr  input  5  pipeline destination register.
REQ-007 wb_w_data  input  32  pipeline write data.
REQ-008 lu_valid  input  1  long-latency unit (div/mul) result valid.
REQ-009 lu_ready  output  1  block can accept an LU result.
REQ-010 lu_w_reg_addr  input  5  LU destination register.
REQ-011 lu_w_data  input  32  LU result data.
REQ-012 rf_we  output  1  register-file write enable (registered).
REQ-013 rf_waddr  output  5  register-file write address (registered).
REQ-014 rf_wdata  output  32  register-file write data (registered).
REQ-015 stallreq  output  1  request to the pipeline controller to insert a WB bubble.
REQ-016 buf_count  output  2  LU buffer occupancy, 0..2.

Function
REQ-017 LU results SHALL be held in a 2-entry FIFO; a push occurs on a clock edge where lu_valid=1 and lu_ready=1.
REQ-018 lu_ready SHALL be combinational: 1 when buf_count<2, else 0.
REQ-019 Grant per cycle: pipeline wins if wb_we=1 and wb_w_reg_addr!=0; otherwise the FIFO head wins if buf_count>0; otherwise idle.
REQ-020 The granted request SHALL appear on rf_we/rf_waddr/rf_wdata one cycle later (latency 1); a FIFO grant pops the head on the same edge.
REQ-021 Writes to register 0 from either source SHALL produce rf_we=0; an LU entry addressed to 0 is popped and discarded when granted.
REQ-022 Idle cycles SHALL drive rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-023 Simultaneous push and pop SHALL leave buf_count unchanged, and FIFO order SHALL be preserved.
REQ-024 A push is not possible when buf_count=2; lu_valid while full is back-pressured and not lost.
REQ-025 Starvation counter (4 bits) SHALL increment on each cycle with buf_count>0 and no FIFO grant, saturating at STARVE_LIMIT.
REQ-026 The starvation counter SHALL clear on any FIFO grant and whenever buf_count=0.
REQ-027 stallreq SHALL be combinational: 1 when counter==STARVE_LIMIT, else 0.
REQ-028 stallreq SHALL stay asserted until the FIFO head is granted; the grant occurs in the first cycle in which wb_we=0.

Reset
REQ-029 While rst=0 the block SHALL drive rf_we=0, rf_waddr=0, rf_wdata=0, buf_count=0, counter=0, stallreq=0 and lu_ready=1.
REQ-030 Reset asserted mid-operation SHALL discard all FIFO contents immediately.
REQ-031 The first push SHALL be accepted on the first rising edge after rst is released.

Configuration
REQ-032 Macro WB_ARB_STARVE_GUARD_EN defined: the starvation counter and stallreq SHALL be implemented per REQ-025..028.
REQ-033 WB_ARB_STARVE_GUARD_EN undefined: no counter is implemented, stallreq SHALL be tied to 0, and the FIFO is served only in cycles where the pipeline does not win.

Verification
REQ-034 wb_we=1, addr=5, data=0xDEADBEEF, no LU -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
REQ-035 LU push addr=7, data=0x12 while wb_we=0 -> buf_count=1 after the edge, then rf_we=1/rf_waddr=7 one cycle later, buf_count=0.
REQ-036 Three LU pushes with wb_we=1 held -> buf_count=2, lu_ready=0, third result held until space frees, FIFO order kept.
REQ-037 Guard enabled, STARVE_LIMIT=4, buf_count=1, wb_we=1 continuously -> stallreq=1 after 4 cycles; wb_we dropped -> LU written next cycle, stallreq=0.
REQ-038 wb_we=1 with addr=0 and one LU entry -> LU entry granted, rf_we=1 with the LU address; an LU entry addressed to 0 -> rf_we=0, entry popped.
REQ-039 rst=0 with buf_count=2 mid-stream -> buf_count=0, rf_we=0 and lu_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/wb_port_arb.sv
// wb_port_arb: arbitrates pipeline writeback and a 2-entry long-latency-unit result FIFO onto one RF write port.
// Optional starvation guard (counter + stallreq) enabled by macro WB_ARB_STARVE_GUARD_EN.
`default_nettype none

module wb_port_arb #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_we,
   input  logic [4:0]  wb_w_reg_addr,
   input  logic [31:0] wb_w_data,
   input  logic        lu_valid,
   output logic        lu_ready,
   input  logic [4:0]  lu_w_reg_addr,
   input  logic [31:0] lu_w_data,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        stallreq,
   output logic [1:0]  buf_count
);

   logic [4:0]  fifo_addr_q [2];
   logic [31:0] fifo_data_q [2];
   logic        rd_ptr_q;
   logic        wr_ptr_q;
   logic [1:0]  count_q;
   logic [1:0]  count_d;

   logic        rf_we_q;
   logic        rf_we_d;
   logic [4:0]  rf_waddr_q;
   logic [4:0]  rf_waddr_d;
   logic [31:0] rf_wdata_q;
   logic [31:0] rf_wdata_d;

   logic        push;
   logic        pipe_win;
   logic        fifo_grant;

   assign lu_ready   = (count_q != 2'd2);
   assign push       = lu_valid & lu_ready;
   assign pipe_win   = wb_we & (wb_w_reg_addr != 5'd0);
   assign fifo_grant = ~pipe_win & (count_q != 2'd0);

   // A granted LU entry addressed to r0 is popped but produces an idle write slot.
   always_comb begin
      rf_we_d    = 1'b0;
      rf_waddr_d = 5'd0;
      rf_wdata_d = 32'd0;
      if (pipe_win) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = wb_w_reg_addr;
         rf_wdata_d = wb_w_data;
      end else if (fifo_grant && (fifo_addr_q[rd_ptr_q] != 5'd0)) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = fifo_addr_q[rd_ptr_q];
         rf_wdata_d = fifo_data_q[rd_ptr_q];
      end
      count_d = count_q + {1'b0, push} - {1'b0, fifo_grant};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fifo_addr_q[0] <= 5'd0;
         fifo_addr_q[1] <= 5'd0;
         fifo_data_q[0] <= 32'd0;
         fifo_data_q[1] <= 32'd0;
         rd_ptr_q       <= 1'b0;
         wr_ptr_q       <= 1'b0;
         count_q        <= 2'd0;
         rf_we_q        <= 1'b0;
         rf_waddr_q     <= 5'd0;
         rf_wdata_q     <= 32'd0;
      end else begin
         if (push) begin
            fifo_addr_q[wr_ptr_q] <= lu_w_reg_addr;
            fifo_data_q[wr_ptr_q] <= lu_w_data;
            wr_ptr_q              <= ~wr_ptr_q;
         end
         if (fifo_grant) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q    <= count_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   assign rf_we     = rf_we_q;
   assign rf_waddr  = rf_waddr_q;
   assign rf_wdata  = rf_wdata_q;
   assign buf_count = count_q;

`ifdef WB_ARB_STARVE_GUARD_EN
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_q;
   logic [3:0] starve_d;

   // Counts cycles a buffered LU result waits without a grant, saturating at the limit.
   always_comb begin
      starve_d = starve_q;
      if ((count_q == 2'd0) || fifo_grant) begin
         starve_d = 4'd0;
      end else if (starve_q != LIMIT) begin
         starve_d = starve_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_q <= 4'd0;
      end else begin
         starve_q <= starve_d;
      end
   end

   assign stallreq = (starve_q == LIMIT);
`else
   logic unused_starve_limit;
   assign unused_starve_limit = ^4'(STARVE_LIMIT);
   assign stallreq            = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arb.sv
// Randomized + directed bench for wb_port_arb against a queue-based reference model.
`default_nettype none

module tb_wb_port_arb;

   localparam int LIMIT = 4;
`ifdef WB_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        wb_we;
   logic [4:0]  wb_w_reg_addr;
   logic [31:0] wb_w_data;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_w_reg_addr;
   logic [31:0] lu_w_data;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        stallreq;
   logic [1:0]  buf_count;

   wb_port_arb #(.STARVE_LIMIT(LIMIT)) dut (
      .clk           (clk),
      .rst           (rst),
      .wb_we         (wb_we),
      .wb_w_reg_addr (wb_w_reg_addr),
      .wb_w_data     (wb_w_data),
      .lu_valid      (lu_valid),
      .lu_ready      (lu_ready),
      .lu_w_reg_addr (lu_w_reg_addr),
      .lu_w_data     (lu_w_data),
      .rf_we         (rf_we),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata),
      .stallreq      (stallreq),
      .buf_count     (buf_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        q[$];
   logic        m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   int          st;
   int          n_vec;
   int          n_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic set(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic lv, input logic [4:0] la, input logic [31:0] ld);
      wb_we = we; wb_w_reg_addr = wa; wb_w_data = wd;
      lu_valid = lv; lu_w_reg_addr = la; lu_w_data = ld;
   endtask

   // Called just after a rising edge with inputs applied; ends just after the next rising edge.
   task automatic step(output bit acc);
      bit   push;
      bit   pipe;
      bit   grant;
      int   size0;
      ent_t e;
      #1;
      size0 = q.size();
      chk("lu_ready", lu_ready, size0 < 2);
      chk("stallreq", stallreq, GUARD && (st == LIMIT));
      chk("buf_count_pre", buf_count, size0);
      push  = lu_valid && (size0 < 2);
      pipe  = wb_we && (wb_w_reg_addr != 5'd0);
      grant = !pipe && (size0 > 0);
      m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0;
      if (pipe) begin
         m_we = 1'b1; m_addr = wb_w_reg_addr; m_data = wb_w_data;
      end else if (grant) begin
         e = q.pop_front();
         if (e.a != 5'd0) begin
            m_we = 1'b1; m_addr = e.a; m_data = e.d;
         end
      end
      if (push) q.push_back({lu_w_reg_addr, lu_w_data});
      if (size0 == 0 || grant) st = 0;
      else if (st < LIMIT) st++;
      acc = push;
      @(posedge clk);
      #1;
      chk("rf_we", rf_we, m_we);
      chk("rf_waddr", rf_waddr, m_addr);
      chk("rf_wdata", rf_wdata, m_data);
      chk("buf_count", buf_count, q.size());
   endtask

   initial begin
      bit          acc;
      bit          pend;
      n_vec = 0; n_err = 0; st = 0;
      q.delete();
      rst = 1'b0;
      set(0, 0, 0, 0, 0, 0);
      #2;
      chk("rst_rf_we", rf_we, 0);
      chk("rst_rf_waddr", rf_waddr, 0);
      chk("rst_rf_wdata", rf_wdata, 0);
      chk("rst_buf_count", buf_count, 0);
      chk("rst_lu_ready", lu_ready, 1);
      chk("rst_stallreq", stallreq, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;

      // First push accepted on the first edge after reset release, then drained
      set(0, 0, 0, 1, 7, 32'h12); step(acc);
      chk("first_push_acc", buf_count, 1);
      set(0, 0, 0, 0, 0, 0); step(acc);
      chk("lu_write_addr7", rf_waddr, 7);

      set(1, 5, 32'hDEADBEEF, 0, 0, 0); step(acc);
      chk("pipe_deadbeef", rf_wdata, 32'hDEADBEEF);

      // Three pushes while the pipeline holds the port; third is back-pressured
      set(1, 9, 32'h9, 1, 1, 32'hA1); step(acc);
      set(1, 9, 32'h9, 1, 2, 32'hA2); step(acc);
      set(1, 9, 32'h9, 1, 3, 32'hA3); step(acc);
      chk("full_not_ready", lu_ready, 0);
      set(1, 9, 32'h9, 1, 3, 32'hA3); step(acc);
      set(0, 0, 0, 1, 3, 32'hA3); step(acc);
      set(0, 0, 0, 1, 3, 32'hA3); step(acc);
      set(0, 0, 0, 0, 0, 0); step(acc); step(acc);

      // Pipeline write to r0 yields to the LU; LU write to r0 is dropped
      set(1, 0, 32'h5, 1, 11, 32'hB0); step(acc);
      set(1, 0, 32'h5, 0, 0, 0); step(acc);
      set(1, 4, 32'h4, 1, 0, 32'hC0); step(acc);
      set(0, 0, 0, 0, 0, 0); step(acc);

      // Starvation: entry waits behind a continuous pipeline stream
      set(1, 4, 32'h44, 1, 13, 32'hD0); step(acc);
      for (int i = 0; i < 5; i++) begin
         set(1, 4, 32'h44 + i, 0, 0, 0); step(acc);
      end
      set(0, 0, 0, 0, 0, 0); step(acc); step(acc);

      // Asynchronous reset with a full buffer
      set(1, 6, 32'h66, 1, 14, 32'hE0); step(acc);
      set(1, 6, 32'h66, 1, 15, 32'hE1); step(acc);
      rst = 1'b0;
      #1;
      chk("arst_buf_count", buf_count, 0);
      chk("arst_rf_we", rf_we, 0);
      chk("arst_lu_ready", lu_ready, 1);
      q.delete(); st = 0;
      @(posedge clk); #1;
      rst = 1'b1;
      set(0, 0, 0, 1, 16, 32'hF0); step(acc);
      set(0, 0, 0, 0, 0, 0); step(acc);

      // Randomized traffic; a refused LU result is held until accepted
      pend = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ((i % 40) < 20) wb_we = ($urandom_range(0, 7) != 0);
         else               wb_we = $urandom_range(0, 1);
         wb_w_reg_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         wb_w_data     = $urandom;
         if (!pend) begin
            lu_valid      = $urandom_range(0, 1);
            lu_w_reg_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            lu_w_data     = $urandom;
         end
         step(acc);
         pend = lu_valid && !acc;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
